// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg: response type, word constants and the byte-lane overflow helper.
package mem_initiator_pkg;
    localparam int WORD_BYTES = 4;
    localparam logic [WORD_BYTES-1:0] BE_ALL = 4'b1111;
    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic        err;
    } rsp_t;
    function automatic logic be_overflow(input logic [1:0] off, input logic [WORD_BYTES-1:0] be);
        logic [2*WORD_BYTES-1:0] sh;
        sh = {{WORD_BYTES{1'b0}}, be} << off;
        return |sh[2*WORD_BYTES-1:WORD_BYTES];
    endfunction
endpackage

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: command, response and RAM data-port signals of mem_initiator.
interface mem_initiator_if #(parameter int ADDR_WIDTH = 22);
    logic                  cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [3:0]            cmd_be;
    logic [31:0]           cmd_wdata;
    logic                  rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  data_req, data_we, data_gnt, data_rvalid;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [3:0]            data_be;
    logic [31:0]           data_wdata, data_rdata;
    modport master (
        input  cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata, rsp_ready, data_gnt, data_rvalid, data_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err, data_req, data_addr, data_we, data_be, data_wdata
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata, rsp_ready, data_gnt, data_rvalid, data_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err, data_req, data_addr, data_we, data_be, data_wdata
    );
endinterface

// File: rtl/mem_initiator_fifo.sv
// mem_initiator_fifo: synchronous FIFO of any type T; a push into a full FIFO is taken only alongside a pop.
module mem_initiator_fifo #(
    parameter type T = logic,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              wdata_i,
    input  logic          pop_i,
    output T              rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    T mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= do_push ? inc(wptr_q) : wptr_q;
            rptr_q <= do_pop ? inc(rptr_q) : rptr_q;
            cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: load/store initiator for the RAM req/gnt/rvalid port with in-order buffered responses.
// Optional alignment check enabled by defining MEM_INITIATOR_ALIGN_CHECK_EN.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH      = 22,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RSP_DEPTH       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_initiator_if.master bus,
    output logic            idle_o
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(RSP_DEPTH + 1);
    logic [OW-1:0]         outst;
    logic [FW-1:0]         fifo_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic we_head, we_full, out_empty;
    logic rsp_full, rsp_empty, rsp_pop, rsp_push;
    logic credit_ok, mis, grant, rv_acc, err_acc, req;
    rsp_t rsp_in, rsp_head;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
    // Misaligned commands bypass the bus; waiting for an empty pipe keeps responses in order.
    assign mis     = be_overflow(bus.cmd_addr[1:0], bus.cmd_be);
    assign err_acc = rst_n && bus.cmd_valid && mis && out_empty && !rsp_full;
`else
    assign mis     = 1'b0;
    assign err_acc = 1'b0;
`endif
    assign addr    = bus.cmd_addr;
    assign rsp_pop = !rsp_empty && bus.rsp_ready;
    // The slot freed by this cycle's pop is counted so a 1-cycle responder runs at full rate.
    assign credit_ok = !we_full && (int'(outst) + int'(fifo_cnt) - int'(rsp_pop) < RSP_DEPTH);
    assign req       = rst_n && bus.cmd_valid && !mis && credit_ok;
    assign grant     = req && bus.data_gnt;
    assign rv_acc    = bus.data_rvalid && !out_empty;
    assign rsp_push  = rv_acc || err_acc;
    assign rsp_in    = rv_acc ? rsp_t'{rdata: we_head ? 32'h0 : bus.data_rdata, we: we_head, err: 1'b0}
                              : rsp_t'{rdata: 32'h0, we: bus.cmd_we, err: 1'b1};
    assign bus.data_req   = req;
    assign bus.data_addr  = addr;
    assign bus.data_we    = bus.cmd_we;
    assign bus.data_be    = bus.cmd_be;
    assign bus.data_wdata = bus.cmd_wdata;
    assign bus.cmd_ready  = grant || err_acc;
    assign bus.rsp_valid  = !rsp_empty;
    assign bus.rsp_rdata  = rsp_head.rdata;
    assign bus.rsp_we     = rsp_head.we;
    assign bus.rsp_err    = rsp_head.err;
    assign idle_o         = out_empty && rsp_empty && !req;
    mem_initiator_fifo #(.T(logic), .DEPTH(MAX_OUTSTANDING)) u_we_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(grant), .wdata_i(bus.cmd_we), .pop_i(rv_acc),
        .rdata_o(we_head), .count_o(outst), .full_o(we_full), .empty_o(out_empty)
    );
    mem_initiator_fifo #(.T(rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rsp_push), .wdata_i(rsp_in), .pop_i(rsp_pop),
        .rdata_o(rsp_head), .count_o(fifo_cnt), .full_o(rsp_full), .empty_o(rsp_empty)
    );
    a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n) bus.data_rvalid |-> !out_empty)
        else $warning("mem_initiator: rvalid with no outstanding transfer ignored");
    a_rsp_room: assert property (@(posedge clk) disable iff (!rst_n) rsp_push |-> !rsp_full || rsp_pop);
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized bench with a RAM responder and an in-order response scoreboard.
`timescale 1ns/1ps
module tb_mem_initiator;
    import mem_initiator_pkg::*;
    logic clk = 0, rst_n = 0, idle;
    always #5 clk = ~clk;
    mem_initiator_if #(.ADDR_WIDTH(22)) bus ();
    mem_initiator #(.ADDR_WIDTH(22), .MAX_OUTSTANDING(2), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .idle_o(idle)
    );
    int vec = 0, miscmp = 0, cyc = 0, acc_n = 0, gnt_n = 0;
    int acc_cyc[$];
    rsp_t obs_q[$], exp_q[$];
    logic [31:0] ram [int];
    logic [31:0] ref_m [int];
    logic [31:0] pend[$];
    bit rv_hold = 0, rv_manual = 0, rnd = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
        return old;
    endfunction

    // Expected response of one accepted command, taken in acceptance order.
    function automatic rsp_t model(input logic [21:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        int w = int'(a >> 2);
        logic [31:0] old = ref_m.exists(w) ? ref_m[w] : 32'h0;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) if (be[i] && i + int'(a[1:0]) > 3) return rsp_t'{rdata: 32'h0, we: we, err: 1'b1};
`endif
        if (we) begin
            ref_m[w] = merge(old, wd, be);
            return rsp_t'{rdata: 32'h0, we: 1'b1, err: 1'b0};
        end
        return rsp_t'{rdata: old, we: 1'b0, err: 1'b0};
    endfunction

    always @(negedge clk) begin : monitor
        int w;
        cyc++;
        if (bus.cmd_valid && bus.cmd_ready) begin acc_n++; acc_cyc.push_back(cyc); end
        if (bus.rsp_valid && bus.rsp_ready) obs_q.push_back(rsp_t'{rdata: bus.rsp_rdata, we: bus.rsp_we, err: bus.rsp_err});
        if (rst_n && bus.data_req && bus.data_gnt) begin
            gnt_n++;
            w = int'(bus.data_addr >> 2);
            if (bus.data_we) begin
                ram[w] = merge(ram.exists(w) ? ram[w] : 32'h0, bus.data_wdata, bus.data_be);
                pend.push_back(32'hBAD0_57E0);
            end else pend.push_back(ram.exists(w) ? ram[w] : 32'h0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd) begin
            bus.data_gnt  = $urandom_range(0, 3) != 0;
            bus.rsp_ready = $urandom_range(0, 2) != 0;
        end
        if (!rv_manual) begin
            if (!rv_hold && pend.size() > 0 && !(rnd && $urandom_range(0, 2) == 0)) begin
                bus.data_rvalid = 1;
                bus.data_rdata  = pend.pop_front();
            end else begin
                bus.data_rvalid = 0;
                bus.data_rdata  = $urandom;
            end
        end
    end

    task automatic set_cmd(input logic [21:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        bus.cmd_valid = 1; bus.cmd_addr = a; bus.cmd_we = we; bus.cmd_be = be; bus.cmd_wdata = wd;
    endtask

    task automatic issue(input logic [21:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd, input string tag);
        bit done = 0;
        set_cmd(a, we, be, wd);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin exp_q.push_back(model(a, we, be, wd)); done = 1; end
            @(posedge clk); #1;
        end
        if (!done) begin vec++; miscmp++; $display("FAIL %s accept: cmd_ready=0 for 300 cycles, required 1", tag); end
        bus.cmd_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(idle && obs_q.size() == exp_q.size()) && n < 500);
        if (n >= 500) begin vec++; miscmp++; $display("FAIL %s drain: idle=%0b rsp=%0d, required idle=1 rsp=%0d", tag, idle, obs_q.size(), exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic clear;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset;
        bus.data_gnt = 1; bus.rsp_ready = 1;
        set_cmd(22'h40, 0, BE_ALL, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if (bus.data_req !== 0) begin miscmp++; $display("FAIL rst req: got %0b, required 0", bus.data_req); end
        vec++; if (bus.cmd_ready !== 0) begin miscmp++; $display("FAIL rst cmd_ready: got %0b, required 0", bus.cmd_ready); end
        vec++; if (bus.rsp_valid !== 0) begin miscmp++; $display("FAIL rst rsp_valid: got %0b, required 0", bus.rsp_valid); end
        vec++; if (idle !== 1) begin miscmp++; $display("FAIL rst idle: got %0b, required 1", idle); end
        bus.cmd_valid = 0;
        @(posedge clk); #1; rst_n = 1;
        rv_hold = 1;
        issue(22'h80, 0, BE_ALL, 0, "rst_load");
        bus.data_gnt = 0;
        set_cmd(22'h84, 0, BE_ALL, 0);
        #3 rst_n = 0;
        #1;
        vec++; if ({bus.data_req, bus.cmd_ready, bus.rsp_valid, idle} !== 4'b0001)
            begin miscmp++; $display("FAIL midrst outputs {req,rdy,rvld,idle}: got %b, required 0001", {bus.data_req, bus.cmd_ready, bus.rsp_valid, idle}); end
        pend.delete(); clear();
        bus.cmd_valid = 0; bus.data_gnt = 1;
        @(posedge clk); #1; rst_n = 1;
        rv_manual = 1; bus.data_rvalid = 1; bus.data_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1; bus.data_rvalid = 0; rv_manual = 0; rv_hold = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if ({bus.rsp_valid, idle} !== 2'b01) begin miscmp++; $display("FAIL stray rvalid {rvld,idle}: got %b, required 01", {bus.rsp_valid, idle}); end
        vec++; if (obs_q.size() != 0) begin miscmp++; $display("FAIL stray rsp count: got %0d, required 0", obs_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        clear();
        issue(22'h100, 1, BE_ALL, 32'hDEAD_BEEF, "sl_store");
        issue(22'h100, 0, BE_ALL, 32'h0, "sl_load");
        drain("sl");
        vec++; if (obs_q.size() != 2) begin miscmp++; $display("FAIL sl count: got %0d, required 2", obs_q.size()); end
        else begin
            vec++; if (obs_q[0] !== rsp_t'{rdata: 32'h0, we: 1'b1, err: 1'b0}) begin miscmp++; $display("FAIL sl store rsp: got %h, required %h", obs_q[0], rsp_t'{rdata: 32'h0, we: 1'b1, err: 1'b0}); end
            vec++; if (obs_q[1] !== rsp_t'{rdata: 32'hDEAD_BEEF, we: 1'b0, err: 1'b0}) begin miscmp++; $display("FAIL sl load rsp: got %h, required %h", obs_q[1], rsp_t'{rdata: 32'hDEAD_BEEF, we: 1'b0, err: 1'b0}); end
        end
    endtask

    task automatic test_gnt_withheld;
        logic [21:0] a = {$urandom_range(0, 4095), 2'b00} + 22'h4000;
        int base;
        clear();
        issue(a, 1, BE_ALL, $urandom, "gw_store");
        drain("gw_pre");
        clear(); base = gnt_n;
        bus.data_gnt = 0;
        set_cmd(a, 0, BE_ALL, 32'h1234_5678);
        repeat (3) begin
            @(negedge clk);
            vec++; if ({bus.data_req, bus.data_addr, bus.cmd_ready} !== {1'b1, a, 1'b0})
                begin miscmp++; $display("FAIL gw hold {req,addr,rdy}: got %0b %h %0b, required 1 %h 0", bus.data_req, bus.data_addr, bus.cmd_ready, a); end
        end
        @(posedge clk); #1; bus.data_gnt = 1;
        issue(a, 0, BE_ALL, 32'h1234_5678, "gw_load");
        drain("gw");
        vec++; if (gnt_n - base != 1) begin miscmp++; $display("FAIL gw grants: got %0d, required 1", gnt_n - base); end
        vec++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin miscmp++; $display("FAIL gw rsp: got %0d entries head %h, required 1 entry %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]); end
    endtask

    task automatic test_backpressure;
        logic [21:0] a[4];
        int base;
        clear();
        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom_range(0, 255), 2'b00} + 22'h8000 + 22'(i * 1024);
            issue(a[i], 1, 4'($urandom_range(1, 15)), $urandom, "bp_store");
        end
        drain("bp_pre");
        clear(); base = acc_n;
        bus.rsp_ready = 0;
        issue(a[0], 0, BE_ALL, 0, "bp_l0");
        issue(a[1], 0, BE_ALL, 0, "bp_l1");
        set_cmd(a[2], 0, BE_ALL, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        vec++; if (acc_n - base != 2) begin miscmp++; $display("FAIL bp accepted: got %0d, required 2", acc_n - base); end
        vec++; if ({bus.data_req, bus.cmd_ready, bus.rsp_valid, idle} !== 4'b0010)
            begin miscmp++; $display("FAIL bp stall {req,rdy,rvld,idle}: got %b, required 0010", {bus.data_req, bus.cmd_ready, bus.rsp_valid, idle}); end
        @(posedge clk); #1; bus.rsp_ready = 1;
        issue(a[2], 0, BE_ALL, 0, "bp_l2");
        issue(a[3], 0, BE_ALL, 0, "bp_l3");
        drain("bp");
        vec++; if (obs_q.size() != 4) begin miscmp++; $display("FAIL bp count: got %0d, required 4", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vec++; if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL bp rsp%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [21:0] base_a = {$urandom_range(0, 1023), 2'b00} + 22'h2_0000;
        int base;
        clear();
        for (int i = 0; i < 8; i++) issue(base_a + 22'(4 * i), 1, 4'($urandom_range(1, 15)), $urandom, "b2b_store");
        drain("b2b_pre");
        clear(); base = acc_cyc.size();
        for (int i = 0; i < 8; i++) issue(base_a + 22'(4 * i), 0, BE_ALL, 0, "b2b_load");
        drain("b2b");
        for (int i = 1; i < 8; i++) begin
            vec++; if (acc_cyc[base + i] - acc_cyc[base + i - 1] != 1) begin miscmp++; $display("FAIL b2b gap%0d: got %0d cycles, required 1", i, acc_cyc[base + i] - acc_cyc[base + i - 1]); end
        end
        vec++; if (obs_q.size() != 8) begin miscmp++; $display("FAIL b2b count: got %0d, required 8", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vec++; if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL b2b rsp%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
    task automatic test_align;
        int base;
        clear(); base = gnt_n;
        rv_hold = 1;
        issue(22'h200, 0, BE_ALL, 0, "al_pending");
        set_cmd(22'h102, 0, BE_ALL, 0);
        repeat (3) begin
            @(negedge clk);
            vec++; if ({bus.data_req, bus.cmd_ready} !== 2'b00) begin miscmp++; $display("FAIL al wait {req,rdy}: got %b, required 00", {bus.data_req, bus.cmd_ready}); end
        end
        @(posedge clk); #1; rv_hold = 0;
        issue(22'h102, 0, BE_ALL, 0, "al_mis");
        drain("al");
        vec++; if (gnt_n - base != 1) begin miscmp++; $display("FAIL al grants: got %0d, required 1", gnt_n - base); end
        vec++; if (obs_q.size() != 2 || obs_q[1] !== rsp_t'{rdata: 32'h0, we: 1'b0, err: 1'b1})
            begin miscmp++; $display("FAIL al rsp: got %0d entries last %h, required 2 entries last %h", obs_q.size(), obs_q.size() ? obs_q[obs_q.size() - 1] : '0, rsp_t'{rdata: 32'h0, we: 1'b0, err: 1'b1}); end
    endtask
`endif

    task automatic test_random;
        clear(); rnd = 1;
        for (int i = 0; i < 40; i++)
            issue({$urandom_range(0, 15), 2'($urandom_range(0, 3))} + 22'h3000, 1'($urandom_range(0, 1)),
                  4'($urandom_range(1, 15)), $urandom, "rnd");
        rnd = 0; bus.data_gnt = 1; bus.rsp_ready = 1;
        drain("rnd");
        vec++; if (obs_q.size() != exp_q.size()) begin miscmp++; $display("FAIL rnd count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vec++; if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL rnd rsp%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_we = 0; bus.cmd_be = 0; bus.cmd_wdata = 0;
        bus.rsp_ready = 1; bus.data_gnt = 1; bus.data_rvalid = 0; bus.data_rdata = 0;
        test_reset();
        test_store_load();
        test_gnt_withheld();
        test_backpressure();
        test_back_to_back();
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, required finish");
        $fatal(1);
    end
endmodule
